// File: rtl/membus_pkg.sv
// Shared types and constants for the external memory bus arbiter.
// Widths, bus direction encodings and FSM state encodings live here.
package membus_pkg;

    localparam int ADDR_W_DFLT = 16;
    localparam int DATA_W_DFLT = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Pointer/index width for 2..4 requesters.
    function automatic int ptr_w(input int nreq);
        return (nreq > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/membus_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning ptr, ptr+1, ... mod NREQ.
// Produces a one-hot pick, its index, and a hit flag when any request is pending.
import membus_pkg::*;

module rr_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  pick,
    output logic [PTR_W-1:0] idx,
    output logic             hit
);

    logic [PTR_W:0] cand;

    always_comb begin
        pick = '0;
        idx  = '0;
        hit  = 1'b0;
        cand = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(off);
            if (cand >= (PTR_W+1)'(NREQ)) begin
                cand = cand - (PTR_W+1)'(NREQ);
            end
            if (!hit && req[cand[PTR_W-1:0]]) begin
                hit                     = 1'b1;
                pick[cand[PTR_W-1:0]]   = 1'b1;
                idx                     = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/membus_arb.sv
// Round-robin arbiter for the single external memory bus, one transaction in flight.
// Optional BUSY timeout with error completion is enabled by defining MEMBUS_TIMEOUT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no transaction; picks next requester from rr_ptr when any req
// ST_BUSY | mem_* and gnt held; waits for mem_rdy (or timeout) to complete
import membus_pkg::*;

module membus_arb #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
`ifdef MEMBUS_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 15
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    input  logic [NREQ-1:0]          req_rw,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     err,
    output logic                     mem_valid,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_rw,
    input  logic                     mem_rdy,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int PTR_W = ptr_w(NREQ);

    state_t           state, state_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] idx_q;
    logic [NREQ-1:0]  pick_oh;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_hit;
    logic             start;
    logic             finish;
    logic             tmo_hit;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (pick_oh),
        .idx  (pick_idx),
        .hit  (pick_hit)
    );

`ifdef MEMBUS_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            wait_cnt <= '0;
        end else if (state == ST_BUSY && !mem_rdy) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Fires on the BUSY cycle whose increment would reach TIMEOUT_CYC; mem_rdy wins.
    assign tmo_hit = (state == ST_BUSY) && !mem_rdy && (wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_hit) begin
                    start     = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_rdy || tmo_hit) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            idx_q     <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rw    <= 1'b0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            if (start) begin
                gnt       <= pick_oh;
                idx_q     <= pick_idx;
                mem_valid <= 1'b1;
                mem_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                mem_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
                mem_rw    <= req_rw[pick_idx];
            end
            if (finish) begin
                // gnt is one-hot on the granted index, so it doubles as the done mask.
                done      <= gnt;
                gnt       <= '0;
                mem_valid <= 1'b0;
                rr_ptr    <= (idx_q == PTR_W'(NREQ - 1)) ? '0 : idx_q + PTR_W'(1);
                if (tmo_hit) begin
                    err   <= 1'b1;
                    rdata <= '0;
                end else if (mem_rw == RW_READ) begin
                    rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
